// File: rtl/lfsr_checker.sv
// LFSR stream checker: hunts for a nonzero seed, verifies three consecutive
// predicted samples before declaring lock, then flywheels the prediction and
// counts mismatches. Four consecutive misses in lock drop back to hunting.
module lfsr_checker (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_number,
  input  logic       clr_err,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic [7:0] expected
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  expected_q, expected_d;
  logic [1:0]  match_cnt_q, match_cnt_d;
  logic [1:0]  miss_cnt_q, miss_cnt_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        err_pulse_q, err_pulse_d;

  logic        sample_match;
  logic        sample_zero;

  // One step of the 8-bit Fibonacci LFSR (taps 4,3,2,0 fed into bit 7).
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
  endfunction

  assign sample_match = (in_number == expected_q);
  assign sample_zero  = (in_number == 8'h00);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; only valid samples move the FSM.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for state_d.
    state_d = state_q;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (!sample_zero) state_d = VERIFY;
        end
        VERIFY: begin
          if (sample_match) begin
            if (match_cnt_q == 2'd2) state_d = LOCK;
          end else if (sample_zero) begin
            state_d = HUNT;
          end
        end
        LOCK: begin
          if (!sample_match && miss_cnt_q == 2'd3) state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Datapath next values: prediction, match/miss counters, error reporting.
  always_comb begin
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (!sample_zero) begin
            expected_d  = lfsr_next(in_number);
            match_cnt_d = 2'd0;
          end
        end
        VERIFY: begin
          if (sample_match) begin
            expected_d = lfsr_next(expected_q);
            if (match_cnt_q == 2'd2) begin
              // Entering lock: start with a clean miss history.
              match_cnt_d = 2'd0;
              miss_cnt_d  = 2'd0;
            end else begin
              match_cnt_d = match_cnt_q + 2'd1;
            end
          end else if (!sample_zero) begin
            // Re-seed from the received sample and restart verification.
            expected_d  = lfsr_next(in_number);
            match_cnt_d = 2'd0;
          end else begin
            // Zero is the lockup value; it cannot be a seed, so go hunting.
            expected_d  = 8'h00;
            match_cnt_d = 2'd0;
          end
        end
        LOCK: begin
          // Flywheel: the prediction advances whether or not the sample agrees.
          expected_d = lfsr_next(expected_q);
          if (sample_match) begin
            miss_cnt_d = 2'd0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            if (miss_cnt_q == 2'd3) begin
              // Lock lost: expected reads as zero while hunting.
              miss_cnt_d  = 2'd0;
              match_cnt_d = 2'd0;
              expected_d  = 8'h00;
            end else begin
              miss_cnt_d = miss_cnt_q + 2'd1;
            end
          end
        end
        default: begin
          expected_d  = 8'h00;
          match_cnt_d = 2'd0;
          miss_cnt_d  = 2'd0;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; it touches nothing else.
    if (clr_err) err_count_d = 8'h00;
  end

  // Datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      expected_q  <= 8'h00;
      match_cnt_q <= 2'd0;
      miss_cnt_q  <= 2'd0;
      err_count_q <= 8'h00;
      err_pulse_q <= 1'b0;
    end else begin
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Output drive: all outputs come straight from registers.
  always_comb begin
    locked    = (state_q == LOCK);
    err_pulse = err_pulse_q;
    err_count = err_count_q;
    expected  = expected_q;
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: acquisition, single error, loss of lock,
// lockup/idle handling, clear priority, saturation and asynchronous reset.
module tb_lfsr_checker;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_number;
  logic       clr_err;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [7:0] expected;

  int vectors;
  int miscompares;

  lfsr_checker dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_number (in_number),
    .clr_err   (clr_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .expected  (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper only: generates matching samples for the long saturation run.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
  endfunction

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] required);
    vectors++;
    if (observed !== required) begin
      miscompares++;
      $display("FAIL %s: got %02h, want %02h", tag, observed, required);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are sampled 1ns
  // after the rising edge that consumes them.
  task automatic step(input logic v, input logic [7:0] num, input logic clr);
    @(negedge clk);
    in_valid  = v;
    in_number = num;
    clr_err   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    in_number = 8'h00;
    clr_err   = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic acquire();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h20, 1'b0);
  endtask

  logic [7:0] exp_m;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b1;
    in_valid    = 1'b0;
    in_number   = 8'h00;
    clr_err     = 1'b0;

    apply_reset();
    check("rst_locked",    {7'd0, locked},    8'h00);
    check("rst_err_pulse", {7'd0, err_pulse}, 8'h00);
    check("rst_err_count", err_count,         8'h00);
    check("rst_expected",  expected,          8'h00);

    // Lockup value and idle cycles leave HUNT untouched.
    step(1'b1, 8'h00, 1'b0);
    check("hunt_zero_locked",   {7'd0, locked},    8'h00);
    check("hunt_zero_expected", expected,          8'h00);
    check("hunt_zero_pulse",    {7'd0, err_pulse}, 8'h00);
    step(1'b0, 8'h55, 1'b0);
    check("hunt_idle_expected", expected,          8'h00);
    check("hunt_idle_pulse",    {7'd0, err_pulse}, 8'h00);

    // VERIFY: seed, idle hold, nonzero reseed, zero returns to HUNT.
    step(1'b1, 8'h01, 1'b0);
    check("seed_expected", expected, 8'h80);
    step(1'b0, 8'h77, 1'b0);
    check("verify_idle_expected", expected, 8'h80);
    step(1'b1, 8'h80, 1'b0);
    check("verify_match_expected", expected, 8'h40);
    step(1'b1, 8'h33, 1'b0);
    check("verify_reseed_expected", expected,          8'h19);
    check("verify_reseed_pulse",    {7'd0, err_pulse}, 8'h00);
    check("verify_reseed_count",    err_count,         8'h00);
    step(1'b1, 8'h00, 1'b0);
    check("verify_zero_expected", expected,       8'h00);
    check("verify_zero_locked",   {7'd0, locked}, 8'h00);

    // Acquire: lock rises on the edge consuming the third match.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    check("acq_not_yet_locked", {7'd0, locked}, 8'h00);
    step(1'b1, 8'h20, 1'b0);
    check("acq_locked",    {7'd0, locked}, 8'h01);
    check("acq_expected",  expected,       8'h10);
    check("acq_err_count", err_count,      8'h00);

    // Single error then recovery; flywheel continues through the miss.
    step(1'b1, 8'h11, 1'b0);
    check("err1_pulse",    {7'd0, err_pulse}, 8'h01);
    check("err1_count",    err_count,         8'h01);
    check("err1_expected", expected,          8'h88);
    step(1'b1, 8'h88, 1'b0);
    check("err1_pulse_gone", {7'd0, err_pulse}, 8'h00);
    check("err1_after_exp",  expected,          8'hC4);
    check("err1_locked",     {7'd0, locked},    8'h01);
    step(1'b0, 8'h00, 1'b0);
    check("lock_idle_expected", expected,          8'hC4);
    check("lock_idle_pulse",    {7'd0, err_pulse}, 8'h00);

    // Loss of lock from a fresh start: four zero samples.
    apply_reset();
    acquire();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h00, 1'b0);
      check($sformatf("loss_pulse_%0d", i), {7'd0, err_pulse}, 8'h01);
      if (i < 3) check($sformatf("loss_locked_%0d", i), {7'd0, locked}, 8'h01);
    end
    check("loss_locked",   {7'd0, locked}, 8'h00);
    check("loss_count",    err_count,      8'h04);
    check("loss_expected", expected,       8'h00);

    // Clear priority: reach 5, then clear with a simultaneous mismatch.
    acquire();
    check("relock_count", err_count, 8'h04);
    step(1'b1, 8'h00, 1'b0);
    check("pre_clr_count", err_count, 8'h05);
    step(1'b1, 8'h00, 1'b1);
    check("clr_count",    err_count,         8'h00);
    check("clr_pulse",    {7'd0, err_pulse}, 8'h01);
    check("clr_locked",   {7'd0, locked},    8'h01);
    check("clr_expected", expected,          8'hC4);
    // A match clears the two misses, so three more do not lose lock.
    step(1'b1, 8'hC4, 1'b0);
    check("miss_clear_expected", expected, 8'hE2);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    check("three_miss_locked", {7'd0, locked}, 8'h01);
    check("three_miss_count",  err_count,      8'h03);

    // Saturation: 300 mismatches, resynchronised by a match after every 3.
    apply_reset();
    acquire();
    exp_m = 8'h10;
    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < 3; j++) begin
        step(1'b1, exp_m ^ 8'h01, 1'b0);
        exp_m = lfsr_next(exp_m);
      end
      step(1'b1, exp_m, 1'b0);
      exp_m = lfsr_next(exp_m);
      if (i == 84) check("sat_reach_ff", err_count, 8'hFF);
    end
    check("sat_count",    err_count,      8'hFF);
    check("sat_locked",   {7'd0, locked}, 8'h01);
    check("sat_expected", expected,       exp_m);

    // Asynchronous reset between edges, mid-LOCK.
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_locked",    {7'd0, locked},    8'h00);
    check("areset_count",     err_count,         8'h00);
    check("areset_expected",  expected,          8'h00);
    check("areset_err_pulse", {7'd0, err_pulse}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    check("post_reset_not_locked", {7'd0, locked}, 8'h00);
    step(1'b1, 8'h20, 1'b0);
    check("post_reset_locked", {7'd0, locked}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
